register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of register addresses; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter ZERO_IDX, default DEPTH-1, meaning the hard-wired zero register address.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset (0 = asserted).
REQ-007 SHALL have port wr_en  input  1  write strobe.
REQ-008 SHALL have port wr_addr  input  AW  write address.
REQ-009 SHALL have port wr_data  input  WIDTH  write data.
REQ-010 SHALL have port rd_addr  input  NRD x AW  per-port read address.
REQ-011 SHALL have port rd_data  output  NRD x WIDTH  per-port registered read data.
REQ-012 SHALL have port rsv_en  input  1  reserve strobe (mark register pending).
REQ-013 SHALL have port rsv_addr  input  AW  reserve address.
REQ-014 SHALL have port busy  output  DEPTH  per-register pending flag.
REQ-015 SHALL have port rd_busy  output  NRD  registered busy flag of each port's read address.

Function
REQ-016 SHALL write wr_data into reg[wr_addr] on rising clk when wr_en=1 and wr_addr != ZERO_IDX.
REQ-017 SHALL ignore writes with wr_addr = ZERO_IDX or wr_addr >= DEPTH; reg[ZERO_IDX] reads 0 always.
REQ-018 SHALL register reads: rd_data[p] at cycle N+1 = value of reg[rd_addr[p]] sampled at edge N (1-cycle latency).
REQ-019 SHALL return 0 on rd_data[p] for rd_addr[p] >= DEPTH.
REQ-020 SHALL serve all NRD ports independently, including identical addresses in the same cycle.
REQ-021 SHALL set busy[rsv_addr] on rising clk when rsv_en=1, except for ZERO_IDX (never busy).
REQ-022 SHALL clear busy[wr_addr] on rising clk when wr_en=1 and wr_addr is valid.
REQ-023 SHALL give reserve priority when rsv_en and wr_en hit the same address in one cycle: data written, busy stays/becomes 1.
REQ-024 SHALL register rd_busy[p] with the same 1-cycle latency and bypass rule as rd_data[p], reflecting busy after that edge's updates.
REQ-025 SHALL have no other internal state; busy and registers change only on clk edges or reset.

Reset
REQ-026 SHALL, while reset=0, asynchronously force all registers, busy, rd_data and rd_busy to 0.
REQ-027 SHALL discard any write or reserve coinciding with reset assertion; first effective edge is the first rising clk with reset=1.

Configuration
REQ-028 SHALL provide macro REGISTER_FILE_BYPASS_EN; when defined, a read at edge N of an address being written at edge N returns the new wr_data and rd_busy reflects the write's clear (subject to REQ-023).
REQ-029 SHALL, without REGISTER_FILE_BYPASS_EN, return the pre-write register value and pre-write busy in that same-address case; new value visible on the next read.

Verification
REQ-030 SHALL cover: reset=0 then release, read addrs 0 and 5 -> rd_data = 0,0; busy = 0.
REQ-031 SHALL cover: write reg3=0x65 then read port0 addr 3 next cycle -> rd_data[0]=0x65 one cycle after read addr applied.
REQ-032 SHALL cover: write ZERO_IDX=0xDEAD, reserve ZERO_IDX, read it -> rd_data=0, busy[ZERO_IDX]=0.
REQ-033 SHALL cover: same edge write reg4=0x3F2 and read addr 4 on both ports -> 0x3F2 with macro, prior value 0 without.
REQ-034 SHALL cover: reserve reg7, then write reg7=600 -> busy[7]=1 then 0; simultaneous reserve+write reg7=700 -> reg7=700, busy[7]=1.
REQ-035 SHALL cover: assert reset mid-sequence after writing reg0=5000 -> reg0, busy, rd_data return to 0 immediately without clk edge.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with a hard-wired zero register
// and a per-register pending (busy) scoreboard.
//
// Parameters:
//   WIDTH    bits per register
//   DEPTH    number of register addresses (AW = $clog2(DEPTH))
//   NRD      number of independent read ports
//   ZERO_IDX address of the register that always reads 0 and is never busy
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wr_en     write strobe; also clears busy of the written register
//   wr_addr   write address
//   wr_data   write data
//   rd_addr   per-port read address (NRD x AW)
//   rd_data   per-port registered read data (NRD x WIDTH), 1-cycle latency
//   rsv_en    reserve strobe; marks rsv_addr pending
//   rsv_addr  reserve address
//   busy      per-register pending flags
//   rd_busy   per-port registered busy flag of the read address
//
// Build option:
//   REGISTER_FILE_BYPASS_EN  when defined, a read of the address being written on the
//                            same edge returns the new data and the post-write busy flag.
//                            When undefined, such a read returns the pre-write values.
module register_file_mp #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_IDX = DEPTH - 1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][WIDTH-1:0] rd_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic [DEPTH-1:0]          busy,
  output logic [NRD-1:0]            rd_busy
);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return 32'(a) == ZERO_IDX;
  endfunction

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [DEPTH-1:0]          busy_q, busy_d;
  logic [NRD-1:0][WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]            rd_busy_q, rd_busy_d;
  logic                      wr_ok, wr_clr, rsv_ok;

  // The zero register is simply never written, so it stays at its reset value of 0.
  always_comb begin
    wr_ok  = wr_en && addr_ok(wr_addr) && !is_zero(wr_addr);
    wr_clr = wr_en && addr_ok(wr_addr);
    rsv_ok = rsv_en && addr_ok(rsv_addr) && !is_zero(rsv_addr);
  end

  // Reserve is applied after the write clear so it wins on a same-address collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_clr) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NRD; p++) begin
      if (addr_ok(rd_addr[p])) begin
        rd_data_d[p] = mem_q[rd_addr[p]];
        rd_busy_d[p] = busy_q[rd_addr[p]];
      end
`ifdef REGISTER_FILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr[p])) begin
        rd_data_d[p] = wr_data;
        rd_busy_d[p] = busy_d[rd_addr[p]];
      end
`else
      // No forwarding: a same-edge write becomes visible on the following read.
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign busy    = busy_q;
  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (WIDTH=64, DEPTH=32, NRD=2, ZERO_IDX=31).
// Expected read results are computed from a reference model when a read is issued,
// queued, and compared one edge later. Honours REGISTER_FILE_BYPASS_EN if defined.
module tb_register_file_mp;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NRD   = 2;
  localparam logic [4:0]  ZERO  = 5'd31;

  logic                      clk;
  logic                      reset;
  logic                      wr_en;
  logic [4:0]                wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [NRD-1:0][4:0]       rd_addr;
  logic [NRD-1:0][WIDTH-1:0] rd_data;
  logic                      rsv_en;
  logic [4:0]                rsv_addr;
  logic [DEPTH-1:0]          busy;
  logic [NRD-1:0]            rd_busy;

  register_file_mp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .rd_busy  (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             b0;
    logic             b1;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
  endtask

  // Issue the currently driven inputs for one edge and check the resulting outputs.
  task automatic tick(input string tag);
    exp_t             e;
    logic [WIDTH-1:0] d [2];
    logic             b [2];
    logic             wok;
    wok = wr_en && (wr_addr != ZERO);
    for (int p = 0; p < 2; p++) begin
      d[p] = m_mem[rd_addr[p]];
      b[p] = m_busy[rd_addr[p]];
`ifdef REGISTER_FILE_BYPASS_EN
      if (wok && (wr_addr == rd_addr[p])) begin
        d[p] = wr_data;
        b[p] = rsv_en && (rsv_addr == wr_addr);
      end
`endif
    end
    e.d0 = d[0];
    e.d1 = d[1];
    e.b0 = b[0];
    e.b1 = b[1];
    sb_q.push_back(e);
    if (wok) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != ZERO)) m_busy[rsv_addr] = 1'b1;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, "/rd_data0"}, rd_data[0], e.d0);
    check({tag, "/rd_data1"}, rd_data[1], e.d1);
    check({tag, "/rd_busy0"}, 64'(rd_busy[0]), 64'(e.b0));
    check({tag, "/rd_busy1"}, 64'(rd_busy[1]), 64'(e.b1));
    check({tag, "/busy"}, 64'(busy), 64'(m_busy));
  endtask

  initial begin
    reset    = 1'b1;
    idle();
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;
    rd_addr[0] = 5'd0;
    rd_addr[1] = 5'd5;
    model_clear();
    #2 reset = 1'b0;
    #1;
    check("reset/rd_data0", rd_data[0], '0);
    check("reset/rd_data1", rd_data[1], '0);
    check("reset/busy", 64'(busy), 64'd0);

    // Write and reserve while reset is held must be discarded.
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 64'hBAD;
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    @(posedge clk);
    #1;
    check("reset_hold/busy", 64'(busy), 64'd0);
    check("reset_hold/rd_busy", 64'(rd_busy), 64'd0);
    idle();
    @(negedge clk);
    reset = 1'b1;

    tick("post_reset_0_5");
    rd_addr[0] = 5'd9;
    tick("discarded_write");

    // Write reg3 then read it on port 0.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h65;
    rd_addr[0] = 5'd0;
    tick("wr3");
    idle();
    rd_addr[0] = 5'd3;
    tick("rd3");

    // Zero register ignores writes and reserves.
    wr_en = 1'b1; wr_addr = ZERO; wr_data = 64'hDEAD;
    rsv_en = 1'b1; rsv_addr = ZERO;
    tick("wr_zero");
    idle();
    rd_addr[0] = ZERO; rd_addr[1] = ZERO;
    tick("rd_zero");
    check("zero_not_busy", 64'(busy[ZERO]), 64'd0);

    // Same-edge write and read of reg4 on both ports.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h3F2;
    rd_addr[0] = 5'd4; rd_addr[1] = 5'd4;
    tick("wr_rd4_same");
    idle();
    tick("rd4_after");

    // Reserve / write / collision on reg7.
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd3;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick("rsv7");
    check("rsv7/busy7", 64'(busy[7]), 64'd1);
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd600;
    tick("wr7_600");
    check("wr7/busy7", 64'(busy[7]), 64'd0);
    wr_data = 64'd700;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick("rsv_wr7_700");
    check("collide/busy7", 64'(busy[7]), 64'd1);
    idle();
    tick("rd7_700");

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr[0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr[1] = 5'($urandom_range(0, 31));
      tick("random");
    end
    idle();

    // Mid-sequence asynchronous reset.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'd5000;
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd2;
    tick("wr0_5000");
    idle();
    rd_addr[0] = 5'd0;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick("rd0_5000");
    idle();
    #2 reset = 1'b0;
    #1;
    check("async_rst/rd_data0", rd_data[0], '0);
    check("async_rst/busy", 64'(busy), 64'd0);
    check("async_rst/rd_busy", 64'(rd_busy), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd12;
    tick("rd0_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
